// File: rtl/rv32_fetch_stage.sv
// ---------------------------------------------------------------------------
// rv32_fetch_stage
//
// Instruction-fetch stage of the RV32I core. Owns the fetch PC, issues one
// instruction-memory read at a time and registers each returned word into the
// IF/ID register together with its PC and PC+4. Decode applies backpressure
// with stall_d, and execute redirects the PC with redirect/redirect_pc.
//
// Optional build macro: RV32_IF_MISALIGN_EN
//   defined   - a misaligned redirect target suppresses fetching and injects a
//               flagged NOP into IF/ID (misalign_d=1); fetch stays idle until
//               the next redirect.
//   undefined - misalign_d is tied 0 and redirect_pc[1:0] is forced to 0.
//
// Ports:
//   clk, reset                    rising-edge clock, async active-high reset
//   imem_req/imem_addr            fetch request and word-aligned byte address
//   imem_gnt                      request accepted this cycle
//   imem_rvalid/imem_rdata        returned instruction word
//   stall_d                       decode cannot accept a new instruction
//   redirect/redirect_pc          taken branch/jump and its target
//   instr_d/pc_d/pcplus4_d        IF/ID register contents
//   valid_d                       IF/ID holds a live instruction
//   misalign_d                    IF/ID entry came from a misaligned redirect
// ---------------------------------------------------------------------------
module rv32_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic        misalign_d
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state_q;
  logic        imem_req_q;
  logic [31:0] pc_f_q;
  logic [31:0] req_pc_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_id_q;
  logic [31:0] pcplus4_q;
  logic        valid_q;

  logic        slot_free;
  logic        consume;
  logic        halt;
  logic [31:0] redirect_target;

  // The IF/ID slot can take a new word if it is empty or being consumed now.
  assign slot_free = !valid_q || !stall_d;
  assign consume   = valid_q && !stall_d;

`ifdef RV32_IF_MISALIGN_EN
  logic misalign_q;
  logic halt_q;
  logic redirect_misaligned;

  assign redirect_target     = redirect_pc;
  assign redirect_misaligned = |redirect_pc[1:0];
  assign halt                = halt_q;
  assign misalign_d          = misalign_q;
`else
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign halt            = 1'b0;
  assign misalign_d      = 1'b0;
`endif

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_f_q;
  assign instr_d   = instr_q;
  assign pc_d      = pc_id_q;
  assign pcplus4_d = pcplus4_q;
  assign valid_d   = valid_q;

  // Fetch FSM and IF/ID register. Later assignments in the same branch
  // override the consume defaults, so a load in the consuming cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      imem_req_q   <= 1'b0;
      pc_f_q       <= RESET_PC;
      req_pc_q     <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      instr_q      <= NOP_INSTR;
      pc_id_q      <= 32'h0;
      pcplus4_q    <= 32'h0;
      valid_q      <= 1'b0;
`ifdef RV32_IF_MISALIGN_EN
      misalign_q   <= 1'b0;
      halt_q       <= 1'b0;
`endif
    end else if (redirect) begin
      pc_f_q       <= redirect_target;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
`ifdef RV32_IF_MISALIGN_EN
      misalign_q   <= 1'b0;
      halt_q       <= 1'b0;
`endif
      // An outstanding read must still be absorbed unless it returns now.
      case (state_q)
        S_WAIT, S_DROP: begin
          if (imem_rvalid) begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
          end else begin
            state_q    <= S_DROP;
            imem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_REQ;
          imem_req_q <= 1'b1;
        end
      endcase
`ifdef RV32_IF_MISALIGN_EN
      // Misaligned target: no fetch, hand decode a flagged NOP and park.
      if (redirect_misaligned) begin
        instr_q    <= NOP_INSTR;
        pc_id_q    <= redirect_pc;
        pcplus4_q  <= redirect_pc + 32'd4;
        valid_q    <= 1'b1;
        misalign_q <= 1'b1;
        halt_q     <= 1'b1;
        state_q    <= S_IDLE;
        imem_req_q <= 1'b0;
      end
`endif
    end else begin
      if (consume) begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
`ifdef RV32_IF_MISALIGN_EN
        misalign_q <= 1'b0;
`endif
      end

      case (state_q)
        S_IDLE: begin
          if (!halt) begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_gnt) begin
            req_pc_q   <= pc_f_q;
            pc_f_q     <= pc_f_q + 32'd4;
            state_q    <= S_WAIT;
            imem_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (slot_free) begin
              instr_q    <= imem_rdata;
              pc_id_q    <= req_pc_q;
              pcplus4_q  <= req_pc_q + 32'd4;
              valid_q    <= 1'b1;
              state_q    <= S_REQ;
              imem_req_q <= 1'b1;
            end else begin
              skid_instr_q <= imem_rdata;
              skid_pc_q    <= req_pc_q;
              state_q      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_d) begin
            instr_q      <= skid_instr_q;
            pc_id_q      <= skid_pc_q;
            pcplus4_q    <= skid_pc_q + 32'd4;
            valid_q      <= 1'b1;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            state_q      <= S_REQ;
            imem_req_q   <= 1'b1;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
